// File: rtl/apb_fifo_subordinate_if.sv
// APB bus bundle between the manager's decoder/mux and the FIFO mailbox subordinate.
interface apb_fifo_subordinate_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/apb_fifo_subordinate.sv
// APB subordinate exposing a word FIFO mailbox, CTRL/STATUS/FLAGS registers
// and a programmable PREADY wait-state count.
module apb_fifo_subordinate #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    apb_fifo_subordinate_if.slave        bus,
    output logic                         IRQ
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] A_STATUS = 2'd0;
    localparam logic [1:0] A_DATA   = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_FLAGS  = 2'd3;

    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_e;

    state_e         state_q, state_d;
    logic [3:0]     wcnt_q, wcnt_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [3:0]     wait_q, wait_d;
    logic           ie_ne_q, ie_ne_d;
    logic           ie_err_q, ie_err_d;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;
    logic [31:0]    mem_q [DEPTH];

    logic           pready_c, done_c, mem_we_c;
    logic           empty_c, full_c;
    logic [PW-1:0]  count_c;
    logic [1:0]     sel_c;
    logic [31:0]    rdata_c;
    logic           unused_addr_c;

    assign unused_addr_c = ^{bus.PADDR[31:4], bus.PADDR[1:0]};
    assign sel_c   = bus.PADDR[3:2];
    assign empty_c = (wptr_q == rptr_q);
    assign full_c  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign count_c = wptr_q - rptr_q;

    assign pready_c = (state_q == S_ACCESS) && (wcnt_q == 4'd0);
    assign done_c   = pready_c && bus.PSEL && bus.PENABLE;

    // Read mux; the DATA head reads as zero when empty.
    always_comb begin
        rdata_c = 32'd0;
        case (sel_c)
            A_STATUS: rdata_c = (32'(count_c) << 8) | {30'd0, full_c, empty_c};
            A_DATA:   rdata_c = empty_c ? 32'd0 : mem_q[rptr_q[AW-1:0]];
            A_CTRL:   rdata_c = {26'd0, ie_err_q, ie_ne_q, wait_q};
            A_FLAGS:  rdata_c = {30'd0, udf_q, ovf_q};
            default:  rdata_c = 32'd0;
        endcase
    end

    assign bus.PREADY = pready_c;
    assign bus.PRDATA = pready_c ? rdata_c : 32'd0;
    assign IRQ        = (ie_ne_q & ~empty_c) | (ie_err_q & (ovf_q | udf_q));

    // Transfer sequencing plus register side effects on the completing cycle.
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        wait_d   = wait_q;
        ie_ne_d  = ie_ne_q;
        ie_err_d = ie_err_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        mem_we_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    state_d = S_ACCESS;
                    wcnt_d  = wait_q;
                end
            end
            S_ACCESS: begin
                if (!bus.PSEL) begin
                    state_d = S_IDLE;
                end else if (!bus.PENABLE) begin
                    wcnt_d = wait_q;
                end else if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (done_c) begin
            case (sel_c)
                A_DATA: begin
                    if (bus.PWRITE) begin
                        if (full_c) begin
                            ovf_d = 1'b1;
                        end else begin
                            mem_we_c = 1'b1;
                            wptr_d   = wptr_q + PW'(1);
                        end
                    end else begin
                        if (empty_c) udf_d  = 1'b1;
                        else         rptr_d = rptr_q + PW'(1);
                    end
                end
                A_CTRL: begin
                    if (bus.PWRITE) begin
                        wait_d   = bus.PWDATA[3:0];
                        ie_ne_d  = bus.PWDATA[4];
                        ie_err_d = bus.PWDATA[5];
                        if (bus.PWDATA[8]) rptr_d = wptr_q;
                    end
                end
                A_FLAGS: begin
                    if (bus.PWRITE) begin
                        ovf_d = ovf_q & ~bus.PWDATA[0];
                        udf_d = udf_q & ~bus.PWDATA[1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            wcnt_q   <= 4'd0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            wait_q   <= 4'd0;
            ie_ne_q  <= 1'b0;
            ie_err_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wait_q   <= wait_d;
            ie_ne_q  <= ie_ne_d;
            ie_err_q <= ie_err_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is not reset; pointers alone define what is valid.
    always_ff @(posedge PCLK) begin
        if (mem_we_c && !PRESET) mem_q[wptr_q[AW-1:0]] <= bus.PWDATA;
    end

endmodule

// File: tb/tb_apb_fifo_subordinate.sv
// Directed APB stimulus with a read-data scoreboard for apb_fifo_subordinate.
module tb_apb_fifo_subordinate;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE = 32'h1000_1000;
    localparam logic [31:0] ST = BASE + 32'h0;
    localparam logic [31:0] DA = BASE + 32'h4;
    localparam logic [31:0] CT = BASE + 32'h8;
    localparam logic [31:0] FL = BASE + 32'hC;

    logic clk = 1'b0;
    logic rst;
    logic irq;
    apb_fifo_subordinate_if bus ();

    always #5 clk = ~clk;

    apb_fifo_subordinate #(.DEPTH(DEPTH)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus),
        .IRQ    (irq)
    );

    int checks = 0;
    int errors = 0;
    int wt = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completing read pops the next expected PRDATA.
    always @(negedge clk) begin
        if (!rst && bus.PSEL && bus.PENABLE) begin
            if (bus.PREADY && !bus.PWRITE) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got %h expected no read", bus.PRDATA);
                end else begin
                    check("prdata", bus.PRDATA, exp_q.pop_front());
                end
            end else if (!bus.PREADY) begin
                check("prdata_wait", bus.PRDATA, 32'd0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the completion edge.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd);
        int n;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = addr;
        bus.PWDATA  = wd;
        if (!wr) exp_q.push_back(exp_rd);
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.PREADY && n < 40);
        check("access_cycles", 32'(n), 32'(wt + 1));
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d);
        xfer(1'b1, addr, d, 32'd0);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        xfer(1'b0, addr, 32'd0, exp);
    endtask

    task automatic idle();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = 32'd0; bus.PWDATA = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pready", 32'(bus.PREADY), 32'd0);
        check("reset_prdata", bus.PRDATA, 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        rst = 1'b0;
        idle();

        rd(ST, 32'h1);
        check("irq_idle", 32'(irq), 32'd0);

        wr(CT, 32'h3);
        wt = 3;
        rd(ST, 32'h1);
        wr(CT, 32'h0);
        wt = 0;

        // Fill, overflow, drain, underflow.
        for (int i = 0; i < 8; i++) wr(DA, 32'hA0 + 32'(i));
        wr(DA, 32'hFF);
        rd(ST, 32'h0000_0802);
        rd(FL, 32'h1);
        for (int i = 0; i < 8; i++) rd((i == 3) ? BASE + 32'h14 : DA, 32'hA0 + 32'(i));
        rd(DA, 32'h0);
        rd(FL, 32'h3);
        idle();

        // Two rounds of 5 across the pointer wrap.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) wr(DA, 32'hB0 + 32'(16 * r + i));
            rd(ST, 32'h0000_0500);
            for (int i = 0; i < 5; i++) begin
                rd(DA, 32'hB0 + 32'(16 * r + i));
                if (i == 1) rd(ST, 32'h0000_0300);
            end
            rd(ST, 32'h1);
        end
        idle();

        check("irq_no_ie", 32'(irq), 32'd0);
        wr(CT, 32'h30);
        check("irq_err", 32'(irq), 32'd1);
        wr(FL, 32'h1);
        rd(FL, 32'h2);
        check("irq_udf", 32'(irq), 32'd1);
        wr(FL, 32'h2);
        check("irq_clear", 32'(irq), 32'd0);
        rd(FL, 32'h0);
        wr(DA, 32'h55);
        check("irq_ne", 32'(irq), 32'd1);
        wr(CT, 32'h130);
        check("irq_flush", 32'(irq), 32'd0);
        rd(CT, 32'h30);
        rd(ST, 32'h1);

        // Reset in the 3rd ACCESS cycle of a DATA write with WAIT=5.
        wr(CT, 32'h35);
        wt = 5;
        wr(DA, 32'h77);
        check("irq_before_reset", 32'(irq), 32'd1);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = DA; bus.PWDATA = 32'h99;
        @(posedge clk); #1;
        bus.PENABLE = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("pready_access3", 32'(bus.PREADY), 32'd0);
        @(posedge clk); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        check("rst_pready", 32'(bus.PREADY), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_prdata", bus.PRDATA, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        wt = 0;
        rd(ST, 32'h1);
        rd(CT, 32'h0);
        rd(FL, 32'h0);
        idle();
        repeat (3) idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
